// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 constants: prefix and discard codes, arrow-key codes and frame FSM states.
// Latency: none (declarations only). Backpressure: none.
package ps2_key_decoder_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Controller/status bytes that never carry a key
  localparam logic [7:0] PS2_CODE_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_CODE_ACK    = 8'hFA;
  localparam logic [7:0] PS2_CODE_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_CODE_RESEND = 8'hFE;
  localparam logic [7:0] PS2_CODE_ERR0   = 8'h00;
  localparam logic [7:0] PS2_CODE_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    FRM_IDLE   = 2'd0,
    FRM_DATA   = 2'd1,
    FRM_PARITY = 2'd2,
    FRM_STOP   = 2'd3
  } frm_state_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == PS2_CODE_PAUSE)  || (b == PS2_CODE_BAT_OK) ||
           (b == PS2_CODE_ACK)    || (b == PS2_CODE_ECHO)   ||
           (b == PS2_CODE_RESEND) || (b == PS2_CODE_ERR0)   ||
           (b == PS2_CODE_ERR1);
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizer, clock-fall detect, 11-bit frame FSM and timeout.
// Latency: rx_valid/rx_err combinational in the cycle the stop-bit fall is seen. Backpressure: none.
module ps2_rx_frame
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  frm_state_t             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TO_W-1:0]        to_q, to_d;

  logic clk_s, dat_s, fall;

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign dat_s   = dat_sync_q[SYNC_STAGES-1];
  assign fall    = clk_prev_q & ~clk_s;
  assign rx_byte = shift_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    clk_prev_d = clk_s;
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_d       = (state_q == FRM_IDLE) ? '0 : to_q + TO_W'(1);
    rx_valid   = 1'b0;
    rx_err     = 1'b0;
    if (fall) begin
      to_d = '0;
      unique case (state_q)
        FRM_IDLE: begin
          if (!dat_s) begin
            state_d = FRM_DATA;
            cnt_d   = 3'd0;
          end
        end
        FRM_DATA: begin
          shift_d[cnt_q] = dat_s;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = FRM_PARITY;
        end
        FRM_PARITY: begin
          par_d   = dat_s;
          state_d = FRM_STOP;
        end
        FRM_STOP: begin
          // Odd parity over data plus parity bit, and stop bit must be high
          if (dat_s && (^{shift_q, par_q})) rx_valid = 1'b1;
          else                              rx_err   = 1'b1;
          state_d = FRM_IDLE;
        end
        default: state_d = FRM_IDLE;
      endcase
    end else if (state_q != FRM_IDLE && to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      rx_err  = 1'b1;
      state_d = FRM_IDLE;
      to_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= FRM_IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      to_q       <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: folds E0/F0 prefixes into held keycode/make/ext levels with a 1-cycle strobe.
// Latency: SYNC_STAGES+1 clk after the raw stop-bit fall. Backpressure: none, events are not queued.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_strobe,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  logic [7:0] keycode_q, keycode_d;
  logic       key_make_q, key_make_d;
  logic       key_ext_q, key_ext_d;
  logic       key_strobe_q, key_strobe_d;
  logic       frame_err_q, frame_err_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always_comb begin
    keycode_d    = keycode_q;
    key_make_d   = key_make_q;
    key_ext_d    = key_ext_q;
    key_strobe_d = 1'b0;
    frame_err_d  = 1'b0;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    if (rx_err) begin
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (!is_discard(rx_byte)) begin
          keycode_d    = rx_byte;
          key_ext_d    = ext_pend_q;
          key_make_d   = ~brk_pend_q;
          key_strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      keycode_q    <= 8'h00;
      key_make_q   <= 1'b0;
      key_ext_q    <= 1'b0;
      key_strobe_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
    end else begin
      keycode_q    <= keycode_d;
      key_make_q   <= key_make_d;
      key_ext_q    <= key_ext_d;
      key_strobe_q <= key_strobe_d;
      frame_err_q  <= frame_err_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
    end
  end

  assign keycode    = keycode_q;
  assign key_make   = key_make_q;
  assign key_ext    = key_ext_q;
  assign key_strobe = key_strobe_q;
  assign frame_err  = frame_err_q;

endmodule
